// File: rtl/alarm_trigger_pkg.sv
// Shared types, BCD limits and BCD helper functions for the alarm trigger slice.
package alarm_trigger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRE   = 2'd1,
        ST_RING   = 2'd2,
        ST_SNOOZE = 2'd3
    } state_t;

    localparam logic [7:0] BCD_MIN_MAX   = 8'h59;
    localparam logic [7:0] BCD_HOUR_MAX  = 8'h23;
    localparam logic [7:0] BCD_SEC_MATCH = 8'h00;

    // Two-digit BCD to binary (values up to 99).
    function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
        return 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
    endfunction

    // Binary (0..99) to two-digit BCD.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] bin);
        return {4'(bin / 7'd10), 4'(bin % 7'd10)};
    endfunction

    // BCD +1 that wraps to 00 after the given maximum.
    function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/alarm_trigger_bcd_time_add.sv
// Combinational BCD (hour, minute) + minutes adder with 60-minute and 24-hour wrap.
module alarm_trigger_bcd_time_add
    import alarm_trigger_pkg::*;
(
    input  logic [7:0] hour,
    input  logic [7:0] min,
    input  logic [5:0] add_min,
    output logic [7:0] sum_hour_c,
    output logic [7:0] sum_min_c
);

    logic [6:0] min_sum;
    logic [6:0] hour_sum;

    // Add in binary, fold minutes into the hour, then wrap the day.
    always_comb begin
        min_sum  = bcd_to_bin(min) + 7'(add_min);
        hour_sum = bcd_to_bin(hour);
        if (min_sum >= 7'd60) begin
            min_sum  = min_sum - 7'd60;
            hour_sum = hour_sum + 7'd1;
        end
        if (hour_sum >= 7'd24)
            hour_sum = hour_sum - 7'd24;
        sum_hour_c = bin_to_bcd(hour_sum);
        sum_min_c  = bin_to_bcd(min_sum);
    end

endmodule

// File: rtl/alarm_trigger.sv
// Alarm compare, ring window, snooze and alarm-time edit; issues the chime start request.
module alarm_trigger
    import alarm_trigger_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN  = 5,
    parameter int unsigned RING_SEC    = 60,
    parameter logic [7:0]  ALARM_RST_H = 8'h07,
    parameter logic [7:0]  ALARM_RST_M = 8'h00
) (
    input  logic       selfClk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    input  logic       alarm_en,
    input  logic       set_en,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       stop,
    input  logic       snooze,
    output logic       message,
    output logic       ringing,
    output logic       snoozed,
    output logic [7:0] alarm_hour,
    output logic [7:0] alarm_min
);

    localparam logic [7:0] RING_LAST  = 8'(RING_SEC);
    localparam logic [5:0] SNOOZE_ADD = 6'(SNOOZE_MIN);

    state_t     state;
    logic [7:0] ring_cnt;
    logic [7:0] snz_hour;
    logic [7:0] snz_min;
    logic [7:0] tgt_hour_c;
    logic [7:0] tgt_min_c;
    logic       alarm_hit_c;
    logic       snooze_hit_c;
    logic       abort_c;

    // Snooze target is always computed from the live time; latched on the snooze pulse.
    alarm_trigger_bcd_time_add u_snooze_add (
        .hour       (cur_hour),
        .min        (cur_min),
        .add_min    (SNOOZE_ADD),
        .sum_hour_c (tgt_hour_c),
        .sum_min_c  (tgt_min_c)
    );

    // Time comparators: only the :00 second on a tick counts as a match.
    always_comb begin
        alarm_hit_c  = sec_tick && (cur_sec == BCD_SEC_MATCH)
                       && (cur_hour == alarm_hour) && (cur_min == alarm_min);
        snooze_hit_c = sec_tick && (cur_sec == BCD_SEC_MATCH)
                       && (cur_hour == snz_hour) && (cur_min == snz_min);
        abort_c      = !alarm_en || set_en;
    end

    // FSM, ring counter, snooze target and alarm edit registers.
    always_ff @(posedge selfClk) begin
        if (reset) begin
            state      <= ST_IDLE;
            message    <= 1'b0;
            ringing    <= 1'b0;
            snoozed    <= 1'b0;
            ring_cnt   <= 8'd0;
            snz_hour   <= 8'h00;
            snz_min    <= 8'h00;
            alarm_hour <= ALARM_RST_H;
            alarm_min  <= ALARM_RST_M;
        end else begin
            message <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (set_en) begin
                        if (inc_hour)
                            alarm_hour <= bcd_inc_wrap(alarm_hour, BCD_HOUR_MAX);
                        if (inc_min)
                            alarm_min <= bcd_inc_wrap(alarm_min, BCD_MIN_MAX);
                    end else if (alarm_en && alarm_hit_c) begin
                        state   <= ST_FIRE;
                        message <= 1'b1;
                    end
                end
                ST_FIRE: begin
                    state    <= ST_RING;
                    ringing  <= 1'b1;
                    ring_cnt <= 8'd0;
                end
                ST_RING: begin
                    if (abort_c || stop) begin
                        state   <= ST_IDLE;
                        ringing <= 1'b0;
                    end else if (snooze) begin
                        state    <= ST_SNOOZE;
                        ringing  <= 1'b0;
                        snoozed  <= 1'b1;
                        snz_hour <= tgt_hour_c;
                        snz_min  <= tgt_min_c;
                    end else if (sec_tick) begin
                        if (ring_cnt + 8'd1 == RING_LAST) begin
                            state   <= ST_IDLE;
                            ringing <= 1'b0;
                        end
                        ring_cnt <= ring_cnt + 8'd1;
                    end
                end
                ST_SNOOZE: begin
                    if (abort_c || stop) begin
                        state   <= ST_IDLE;
                        snoozed <= 1'b0;
                    end else if (snooze_hit_c) begin
                        state   <= ST_FIRE;
                        snoozed <= 1'b0;
                        message <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ringing <= 1'b0;
                    snoozed <= 1'b0;
                end
            endcase
        end
    end

endmodule
